// File: rtl/rv_pkg.sv
// Shared constants for the single-cycle RISC-V core: data width, memory-op
// ALU encodings and the default data-memory geometry.
package rv_pkg;
  localparam int XLEN = 32;

  localparam logic [4:0] OP_LW = 5'b10100;
  localparam logic [4:0] OP_SW = 5'b10101;

  localparam int          DMEM_DEPTH = 1024;
  localparam logic [31:0] DMEM_BASE  = 32'h0000_0000;
endpackage

// File: rtl/dmem_ram.sv
// Behavioural word array: synchronous write, asynchronous read. Kept separate
// so it can be replaced by a vendor block RAM without touching the decode.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dmem_unit.sv
// Data memory for the MEM stage: single-cycle loads, synchronous stores,
// address/alignment checking with a sticky fault record and event counters.
module dmem_unit
  import rv_pkg::*;
#(
  parameter int          DEPTH_WORDS = DMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic             we_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [XLEN-1:0]  rdata_o,
  output logic             fault_o,
  output logic [XLEN-1:0]  fault_addr_o,
  input  logic             fault_clr_i,
  output logic [CNT_W-1:0] load_cnt_o,
  output logic [CNT_W-1:0] store_cnt_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  // Span is held at 33 bits so a window covering the whole 4 GiB still compares.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [XLEN-1:0]  w_off;
  logic             w_in_range;
  logic             w_aligned;
  logic [AW-1:0]    w_index;
  logic             w_good;
  logic             w_bad;
  logic             w_ram_we;
  logic [XLEN-1:0]  w_ram_rdata;

  logic             r_fault;
  logic [XLEN-1:0]  r_fault_addr;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_store_cnt;

  assign w_off      = addr_i - BASE_ADDR;
  assign w_in_range = (addr_i >= BASE_ADDR) && ({1'b0, w_off} < SPAN_BYTES);
  assign w_aligned  = (addr_i[1:0] == 2'b00);
  assign w_index    = w_off[AW+1:2];
  assign w_good     = ce_i & w_in_range & w_aligned & ~rst;
  assign w_bad      = ce_i & ~(w_in_range & w_aligned) & ~rst;
  assign w_ram_we   = w_good & we_i;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_waddr(w_index),
    .i_wdata(wdata_i),
    .i_raddr(w_index),
    .o_rdata(w_ram_rdata)
  );

  // Load data only escapes on a good load; stores, faults, idle and reset read 0.
  assign rdata_o = (w_good & ~we_i) ? w_ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_bad) begin
      r_fault      <= 1'b1;
      r_fault_addr <= addr_i;
    end else if (fault_clr_i) begin
      r_fault      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
    end else begin
      if (w_good & ~we_i) r_load_cnt  <= r_load_cnt + CNT_W'(1);
      if (w_good & we_i)  r_store_cnt <= r_store_cnt + CNT_W'(1);
    end
  end

  assign fault_o      = r_fault;
  assign fault_addr_o = r_fault_addr;
  assign load_cnt_o   = r_load_cnt;
  assign store_cnt_o  = r_store_cnt;
endmodule
